ram_loader: RTL and testbench
=============================

// Module: ram_loader
// PURPOSE
//   Boot-time program loader sitting directly upstream of the NBBPU RAM write port.
//   Consumes a byte stream (valid/ready) carrying a word-count header then little-endian
//   16-bit words, writes them to consecutive RAM words, and holds the CPU until loading ends.
//   Its write outputs drive the RAM's write_enable/address/write_data ports (byte address, bit 0 = 0).
// PARAMETERS
//   RAM_WORDS     256      capacity of target RAM in 16-bit words; larger counts are rejected
//   BASE_ADDRESS  16'h0000 byte address of first word written; must be even
// PORTS
//   clock             input   1   system clock, all state on posedge
//   reset             input   1   asynchronous, active-high reset
//   rx_data           input   8   incoming byte
//   rx_valid          input   1   rx_data valid this cycle
//   rx_ready          output  1   loader accepts byte; transfer when rx_valid && rx_ready
//   ram_write_enable  output  1   one-cycle write strobe to RAM
//   ram_address       output  16  byte address of word being written (bit 0 always 0)
//   ram_write_data    output  16  word to write
//   cpu_hold          output  1   keeps CPU in reset while high
//   done              output  1   load finished (level, sticky until reset)
//   error             output  1   load rejected (level, sticky until reset)
// BEHAVIOUR
//   Reset (async assert): state=COUNT_LO, rx_ready=1, ram_write_enable=0, ram_address=BASE_ADDRESS,
//     ram_write_data=0, cpu_hold=1, done=0, error=0; counters cleared. Mid-load reset aborts;
//     RAM words already written are left as is.
//   States: COUNT_LO -> COUNT_HI -> (DATA_LO -> DATA_HI -> WRITE)* -> [CHECK_LO -> CHECK_HI] -> DONE.
//   Byte order: first byte = bits [7:0], second = [15:8], for count, data and checksum.
//   rx_ready=1 only in COUNT_*, DATA_*, CHECK_*; 0 in WRITE and DONE. States advance only on transfer.
//   COUNT_HI transfer: count==0 -> DONE (or CHECK_LO with checksum); count>RAM_WORDS -> error=1, DONE.
//   DATA_HI transfer: word latched into ram_write_data; next cycle WRITE asserts ram_write_enable
//     for exactly 1 cycle; ram_address increments by 2 the cycle after the strobe.
//   Latency: write strobe 1 cycle after the accepting DATA_HI edge; next byte accepted the cycle after.
//   Address is 16-bit; wrap past 16'hFFFE is unreachable given the RAM_WORDS check.
//   After last WRITE: DONE (or CHECK_LO). DONE: done=1; cpu_hold=0 if error==0, else stays 1.
//   DONE is terminal until reset; rx_valid ignored, no further writes.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined: after data, two bytes carry the expected 16-bit sum (mod 2^16) of all
//     data words. Mismatch -> error=1, cpu_hold stays 1; match -> cpu_hold=0. CHECK_* states exist.
//   Not defined: no checksum bytes expected; last WRITE goes straight to DONE; error set only by
//     oversize count.
// STRUCTURE
//   Shared include loader_defs.vh: state encodings (3-bit localparams), byte-order constants.
//   One sub-module: byte_pair_assembler (accepts two bytes, presents a 16-bit word + word_valid pulse);
//     reused for count, data and checksum. FSM, address counter and word counter stay in ram_loader.
// TESTING
//   Bytes 03 00 | 34 12 | 78 56 | BC 9A -> writes 1234@0000, 5678@0002, 9ABC@0004; done=1, cpu_hold=0.
//   rx_valid with gaps of 0-3 idle cycles, count=2 -> same writes; rx_ready=0 during each WRITE cycle.
//   Count 01 01 (257) with RAM_WORDS=256 -> no strobe, error=1, done=1, cpu_hold=1.
//   Count 00 00 -> no writes, done=1 (with checksum: expects 00 00; matches, cpu_hold=0).
//   reset pulsed after 2 of 4 words -> outputs return to reset values; reload of 4 words succeeds.
//   LOADER_CHECKSUM_EN, words 0001,FFFF, sum bytes 00 00 -> cpu_hold=0; sum bytes 01 00 -> error=1.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// Shared definitions for the boot-time RAM loader: FSM state encodings and byte-order helpers.
package ram_loader_pkg;

  typedef enum logic [2:0] {
    ST_COUNT_LO = 3'd0,
    ST_COUNT_HI = 3'd1,
    ST_DATA_LO  = 3'd2,
    ST_DATA_HI  = 3'd3,
    ST_WRITE    = 3'd4,
    ST_CHECK_LO = 3'd5,
    ST_CHECK_HI = 3'd6,
    ST_DONE     = 3'd7
  } loader_state_t;

  localparam int          BYTE_W    = 8;
  localparam int          WORD_W    = 16;
  localparam logic [15:0] ADDR_STEP = 16'd2;

  // Little-endian: the first byte on the wire is the low half of the word.
  function automatic logic [WORD_W-1:0] join_bytes(input logic [BYTE_W-1:0] first_byte,
                                                   input logic [BYTE_W-1:0] second_byte);
    return {second_byte, first_byte};
  endfunction

endpackage

// File: rtl/ram_loader_byte_pair_assembler.sv
// Pairs consecutive accepted bytes into a little-endian 16-bit word; o_word_valid pulses
// combinationally with the accepting of the second byte.
module ram_loader_byte_pair_assembler
  import ram_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic              i_byte_valid,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_valid
);

  logic [BYTE_W-1:0] r_first;
  logic              r_phase;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_first <= '0;
      r_phase <= 1'b0;
    end else if (i_byte_valid) begin
      if (!r_phase) r_first <= i_byte;
      r_phase <= ~r_phase;
    end
  end

  assign o_word       = join_bytes(r_first, i_byte);
  assign o_word_valid = i_byte_valid & r_phase;

endmodule

// File: rtl/ram_loader.sv
// Byte-stream program loader feeding a RAM write port; holds the CPU until the load ends.
// Define LOADER_CHECKSUM_EN to expect a trailing 16-bit sum of all data words.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int          RAM_WORDS    = 256,
  parameter logic [15:0] BASE_ADDRESS = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        ram_write_enable,
  output logic [15:0] ram_address,
  output logic [15:0] ram_write_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam logic [16:0] MAX_WORDS = 17'(RAM_WORDS);

  loader_state_t r_state;
  loader_state_t w_state_next;
  logic [15:0]   r_remaining;
  logic [15:0]   r_address;
  logic [15:0]   r_write_data;
  logic          r_error;
  logic          w_transfer;
  logic [15:0]   w_word;
  logic          w_word_valid;
  logic          w_oversize;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]   r_sum;
`endif

  assign w_transfer = rx_valid & rx_ready;
  assign w_oversize = {1'b0, w_word} > MAX_WORDS;

  ram_loader_byte_pair_assembler u_pair (
    .clock        (clock),
    .reset        (reset),
    .i_byte       (rx_data),
    .i_byte_valid (w_transfer),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_COUNT_LO;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_COUNT_LO: if (w_transfer) w_state_next = ST_COUNT_HI;
      ST_COUNT_HI: begin
        if (w_word_valid) begin
          if (w_oversize)           w_state_next = ST_DONE;
`ifdef LOADER_CHECKSUM_EN
          else if (w_word == 16'd0) w_state_next = ST_CHECK_LO;
`else
          else if (w_word == 16'd0) w_state_next = ST_DONE;
`endif
          else                      w_state_next = ST_DATA_LO;
        end
      end
      ST_DATA_LO:  if (w_transfer) w_state_next = ST_DATA_HI;
      ST_DATA_HI:  if (w_word_valid) w_state_next = ST_WRITE;
      ST_WRITE: begin
        if (r_remaining != 16'd1) w_state_next = ST_DATA_LO;
`ifdef LOADER_CHECKSUM_EN
        else                      w_state_next = ST_CHECK_LO;
`else
        else                      w_state_next = ST_DONE;
`endif
      end
      ST_CHECK_LO: if (w_transfer) w_state_next = ST_CHECK_HI;
      ST_CHECK_HI: if (w_word_valid) w_state_next = ST_DONE;
      ST_DONE:     w_state_next = ST_DONE;
      default:     w_state_next = ST_COUNT_LO;
    endcase
  end

  always_comb begin
    rx_ready         = 1'b0;
    ram_write_enable = 1'b0;
    done             = 1'b0;
    cpu_hold         = 1'b1;
    case (r_state)
      ST_COUNT_LO, ST_COUNT_HI, ST_DATA_LO, ST_DATA_HI, ST_CHECK_LO, ST_CHECK_HI:
        rx_ready = 1'b1;
      ST_WRITE:
        ram_write_enable = 1'b1;
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = r_error;
      end
      default: ;
    endcase
  end

  // Address advances on the edge that ends the write strobe, so the strobe sees the old value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_remaining  <= '0;
      r_address    <= BASE_ADDRESS;
      r_write_data <= '0;
      r_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum        <= '0;
`endif
    end else begin
      case (r_state)
        ST_COUNT_HI: if (w_word_valid) begin
          r_remaining <= w_word;
          if (w_oversize) r_error <= 1'b1;
        end
        ST_DATA_HI: if (w_word_valid) begin
          r_write_data <= w_word;
`ifdef LOADER_CHECKSUM_EN
          r_sum        <= r_sum + w_word;
`endif
        end
        ST_WRITE: begin
          r_address   <= r_address + ADDR_STEP;
          r_remaining <= r_remaining - 16'd1;
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK_HI: if (w_word_valid && (w_word != r_sum)) r_error <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign ram_address    = r_address;
  assign ram_write_data = r_write_data;
  assign error          = r_error;

endmodule

// File: tb/tb_ram_loader.sv
// Randomized self-checking bench for ram_loader: expected RAM writes and final status are
// derived from the word list sent, and compared with writes captured on the RAM port.
module tb_ram_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        ram_write_enable;
  logic [15:0] ram_address;
  logic [15:0] ram_write_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  ram_loader dut (
    .clock            (clock),
    .reset            (reset),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .cpu_hold         (cpu_hold),
    .done             (done),
    .error            (error)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Capture every write strobe seen on the RAM port.
  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          ready_viol = 0;
  int          long_strobe = 0;
  logic        prev_we = 1'b0;

  always @(negedge clock) begin
    if (ram_write_enable === 1'b1) begin
      wr_addr_q.push_back(ram_address);
      wr_data_q.push_back(ram_write_data);
      if (rx_ready !== 1'b0) ready_viol++;
      if (prev_we === 1'b1) long_strobe++;
    end
    prev_we = ram_write_enable;
  end

  logic [15:0] stim_words[$];

  function automatic int pick_gap(input int max_gap);
    return (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input bit expect_strobe);
    int waited;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    while (rx_ready !== 1'b1 && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (rx_ready !== 1'b1) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge clock);
    if (expect_strobe) check("strobe_latency", 32'(ram_write_enable), 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_write_enable", 32'(ram_write_enable), 32'd0);
    check("rst_address", 32'(ram_address), 32'h0000);
    check("rst_write_data", 32'(ram_write_data), 32'h0000);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    rx_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [15:0] count_field, input int max_gap,
                          input logic [15:0] sum_delta);
    int          base_n;
    int          base_rv;
    int          base_ls;
    int          exp_n;
    int          got_n;
    logic        exp_err;
    logic [15:0] sum;
    base_n  = wr_addr_q.size();
    base_rv = ready_viol;
    base_ls = long_strobe;
    send_byte(count_field[7:0], pick_gap(max_gap), 1'b0);
    send_byte(count_field[15:8], pick_gap(max_gap), 1'b0);
    exp_err = (count_field > 16'd256);
    exp_n   = exp_err ? 0 : stim_words.size();
    sum     = 16'h0000;
    if (!exp_err) begin
      foreach (stim_words[i]) begin
        send_byte(stim_words[i][7:0], pick_gap(max_gap), 1'b0);
        send_byte(stim_words[i][15:8], pick_gap(max_gap), 1'b1);
        sum = sum + stim_words[i];
      end
      sum = sum + sum_delta;
`ifdef LOADER_CHECKSUM_EN
      send_byte(sum[7:0], pick_gap(max_gap), 1'b0);
      send_byte(sum[15:8], pick_gap(max_gap), 1'b0);
      if (sum_delta != 16'h0000) exp_err = 1'b1;
`endif
    end
    repeat (3) @(negedge clock);
    got_n = wr_addr_q.size() - base_n;
    check({tag, "_n_writes"}, 32'(got_n), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      if (base_n + i < wr_addr_q.size()) begin
        check({tag, "_addr"}, 32'(wr_addr_q[base_n + i]), 32'(16'(2 * i)));
        check({tag, "_data"}, 32'(wr_data_q[base_n + i]), 32'(stim_words[i]));
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_error"}, 32'(error), 32'(exp_err));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(exp_err));
    check({tag, "_ready_in_write"}, 32'(ready_viol - base_rv), 32'd0);
    check({tag, "_strobe_width"}, 32'(long_strobe - base_ls), 32'd0);
    rx_valid = 1'b1;
    repeat (4) begin
      rx_data = 8'($urandom);
      @(negedge clock);
      check({tag, "_done_ready"}, 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;
    check({tag, "_done_no_write"}, 32'(wr_addr_q.size() - base_n), 32'(exp_n));
    check({tag, "_done_sticky"}, 32'(done), 32'd1);
    $display("load %s: count=%0d writes=%0d sum=%04h error=%0d", tag, count_field, got_n, sum, error);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    do_reset();
    stim_words = '{16'h1234, 16'h5678, 16'h9ABC};
    run_load("example", 16'd3, 0, 16'h0000);

    do_reset();
    stim_words = '{16'($urandom), 16'($urandom)};
    run_load("gaps", 16'd2, 3, 16'h0000);

    do_reset();
    stim_words = {};
    run_load("oversize", 16'h0101, 1, 16'h0000);

    do_reset();
    stim_words = {};
    run_load("empty", 16'd0, 2, 16'h0000);

    // Abort a 4-word load after two words, then reload from scratch.
    do_reset();
    stim_words = '{16'hA001, 16'hB002, 16'hC003, 16'hD004};
    send_byte(8'h04, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      send_byte(stim_words[i][7:0], 1, 1'b0);
      send_byte(stim_words[i][15:8], 1, 1'b1);
    end
    do_reset();
    run_load("reload", 16'd4, 2, 16'h0000);

    do_reset();
    stim_words = {};
    for (int i = 0; i < 256; i++) stim_words.push_back(16'($urandom));
    run_load("full", 16'd256, 0, 16'h0000);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    stim_words = '{16'h0001, 16'hFFFF};
    run_load("sum_ok", 16'd2, 1, 16'h0000);
    do_reset();
    run_load("sum_bad", 16'd2, 1, 16'h0001);
`endif

    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = int'($urandom_range(8, 1));
      stim_words = {};
      for (int i = 0; i < n; i++) stim_words.push_back(16'($urandom));
      run_load("random", 16'(n), 3, 16'h0000);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
